mem_wb_stage: RTL and testbench

Fourth and fifth pipeline stage of the MIPS core: holds the EX/MEM pipeline register, drives the external data bus for loads and stores, and produces the MEM/WB register that feeds the register-file write port. Sits directly downstream of the execute stage (ALU/multiplier output mux) and upstream of the register file. A parameterised bus wait-state counter stalls the upstream pipeline while an access is in progress.

---
 rtl/mips_pkg.sv | 38 +++
 rtl/mem_wait_ctrl.sv | 34 +++
 rtl/mem_wb_stage.sv | 93 +++++++++
 tb/tb_mem_wb_stage.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core pipeline.
// Holds FSM encodings, control-word layout and default widths.
package mips_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } wait_state_t;

    // Control-word bit positions produced by the decoder.
    localparam int CW_MUX_ALU_IN  = 0;
    localparam int CW_ALU_OP_LO   = 1;
    localparam int CW_ALU_OP_HI   = 2;
    localparam int CW_START       = 3;
    localparam int CW_MUX_ALU_OUT = 4;
    localparam int CW_MEM_WR      = 5;
    localparam int CW_MUX_WB      = 6;
    localparam int CW_RF_WR       = 7;
    localparam int CW_RD_LO       = 8;
    localparam int CW_RD_HI       = 12;
    localparam int CW_RT_LO       = 13;
    localparam int CW_RT_HI       = 17;
    localparam int CW_RS_LO       = 18;
    localparam int CW_RS_HI       = 22;

    // Loads and stores both occupy the data bus.
    function automatic logic is_mem_op(
        input logic valid,
        input logic mem_wr,
        input logic wb_sel
    );
        return valid & (mem_wr | wb_sel);
    endfunction

endpackage

// File: rtl/mem_wait_ctrl.sv
// Bus wait-state controller for the memory stage.
// Tracks whether the EX/MEM register holds a bus access and counts its cycles.
module mem_wait_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic stall
);

    localparam logic [3:0] LAST = 4'(WAIT_CYCLES);

    wait_state_t state;
    logic [3:0]  cnt;

    // A non-stalled edge loads a new instruction; a stalled edge advances cnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else if (!stall) begin
            cnt   <= 4'd0;
            state <= start ? ACCESS : IDLE;
        end else begin
            cnt   <= cnt + 4'd1;
        end
    end

    assign stall = (state == ACCESS) && (cnt != LAST);

endmodule

// File: rtl/mem_wb_stage.sv
// MEM and WB pipeline stages: EX/MEM register, data bus drive, MEM/WB register.
// Upstream is held through the stall output while a bus access is in progress.
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int          DATA_W      = DATA_W_DEF,
    parameter int          REG_AW      = REG_AW_DEF,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_alu_out,
    input  logic [DATA_W-1:0] in_store_data,
    input  logic              in_mem_wr,
    input  logic              in_wb_sel,
    input  logic              in_rf_wr,
    input  logic [REG_AW-1:0] in_rd,
    output logic              stall,
    output logic [DATA_W-1:0] ADDR,
    output logic [DATA_W-1:0] data_BUS_WRITE,
    output logic              cs,
    output logic              we,
    input  logic [DATA_W-1:0] Data_BUS_READ,
    output logic [DATA_W-1:0] wb_data,
    output logic [REG_AW-1:0] wb_rd,
    output logic              wb_write
);

    logic              m_valid;
    logic [DATA_W-1:0] m_alu_out;
    logic [DATA_W-1:0] m_store_data;
    logic              m_mem_wr;
    logic              m_wb_sel;
    logic              m_rf_wr;
    logic [REG_AW-1:0] m_rd;

    logic start;

    assign start = is_mem_op(in_valid, in_mem_wr, in_wb_sel);

    mem_wait_ctrl #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .stall(stall)
    );

    // Bus signals come straight from M so they stay stable across wait states.
    assign ADDR           = m_alu_out;
    assign data_BUS_WRITE = m_store_data;
    assign cs             = is_mem_op(m_valid, m_mem_wr, m_wb_sel);
    assign we             = m_valid & m_mem_wr;

    // EX/MEM register: loads on every non-stalled edge, bubbles clear valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid      <= 1'b0;
            m_alu_out    <= '0;
            m_store_data <= '0;
            m_mem_wr     <= 1'b0;
            m_wb_sel     <= 1'b0;
            m_rf_wr      <= 1'b0;
            m_rd         <= '0;
        end else if (!stall) begin
            m_valid      <= in_valid;
            m_alu_out    <= in_alu_out;
            m_store_data <= in_store_data;
            m_mem_wr     <= in_mem_wr;
            m_wb_sel     <= in_wb_sel;
            m_rf_wr      <= in_rf_wr;
            m_rd         <= in_rd;
        end
    end

    // MEM/WB register: read data is taken only on the completing cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_data  <= '0;
            wb_rd    <= '0;
            wb_write <= 1'b0;
        end else if (!stall) begin
            wb_data  <= m_wb_sel ? Data_BUS_READ : m_alu_out;
            wb_rd    <= m_rd;
            wb_write <= m_valid & m_rf_wr;
        end else begin
            wb_write <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage: four instances with WAIT_CYCLES 0..3.
// Upstream queue, bus responder and writeback scoreboard drive the checks.
module tb_mem_wb_stage;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int N  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          in_valid;
    logic [DW-1:0] in_alu_out;
    logic [DW-1:0] in_store_data;
    logic          in_mem_wr;
    logic          in_wb_sel;
    logic          in_rf_wr;
    logic [AW-1:0] in_rd;
    logic [DW-1:0] Data_BUS_READ;

    logic          stall_v [N];
    logic          cs_v    [N];
    logic          we_v    [N];
    logic          wbw_v   [N];
    logic [DW-1:0] addr_v  [N];
    logic [DW-1:0] wdat_v  [N];
    logic [DW-1:0] wbd_v   [N];
    logic [AW-1:0] wbr_v   [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        mem_wb_stage #(
            .DATA_W     (DW),
            .REG_AW     (AW),
            .WAIT_CYCLES(g)
        ) dut (
            .clk           (clk),
            .rst           (rst),
            .in_valid      (in_valid),
            .in_alu_out    (in_alu_out),
            .in_store_data (in_store_data),
            .in_mem_wr     (in_mem_wr),
            .in_wb_sel     (in_wb_sel),
            .in_rf_wr      (in_rf_wr),
            .in_rd         (in_rd),
            .stall         (stall_v[g]),
            .ADDR          (addr_v[g]),
            .data_BUS_WRITE(wdat_v[g]),
            .cs            (cs_v[g]),
            .we            (we_v[g]),
            .Data_BUS_READ (Data_BUS_READ),
            .wb_data       (wbd_v[g]),
            .wb_rd         (wbr_v[g]),
            .wb_write      (wbw_v[g])
        );
    end

    typedef struct {
        logic          mem_wr;
        logic          wb_sel;
        logic          rf_wr;
        logic [AW-1:0] rd;
        logic [DW-1:0] alu;
        logic [DW-1:0] sd;
    } op_t;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
        int            cyc;
    } wb_t;

    typedef struct {
        logic [DW-1:0] addr;
        logic [DW-1:0] data;
        logic          w;
        int            cyc;
    } bus_t;

    op_t  up_q  [$];
    wb_t  exp_q [$];
    wb_t  got_q [$];
    bus_t bus_q [$];

    int cyc;
    int sel;
    int cs_cnt;
    int we_cnt;
    int stall_cnt;
    int passed;
    int total;
    logic [DW-1:0] rdata_cur;

    task automatic drive_inputs();
        if (up_q.size() > 0) begin
            in_valid      = 1'b1;
            in_mem_wr     = up_q[0].mem_wr;
            in_wb_sel     = up_q[0].wb_sel;
            in_rf_wr      = up_q[0].rf_wr;
            in_rd         = up_q[0].rd;
            in_alu_out    = up_q[0].alu;
            in_store_data = up_q[0].sd;
        end else begin
            in_valid      = 1'b0;
            in_mem_wr     = 1'b0;
            in_wb_sel     = 1'b0;
            in_rf_wr      = 1'b0;
            in_rd         = '0;
            in_alu_out    = '0;
            in_store_data = '0;
        end
    endtask

    task automatic bus_respond();
        if (cs_v[sel] && !stall_v[sel])
            Data_BUS_READ = rdata_cur;
        else
            Data_BUS_READ = 32'h0BAD_0BAD;
    endtask

    task automatic clear_mon();
        cs_cnt    = 0;
        we_cnt    = 0;
        stall_cnt = 0;
        got_q.delete();
        bus_q.delete();
    endtask

    task automatic step();
        logic st;
        logic rs;
        st = stall_v[sel];
        rs = rst;
        @(posedge clk);
        #1;
        cyc++;
        if (!st && !rs && up_q.size() > 0)
            up_q.delete(0);
        if (cs_v[sel])
            cs_cnt++;
        if (we_v[sel])
            we_cnt++;
        if (stall_v[sel])
            stall_cnt++;
        if (wbw_v[sel])
            got_q.push_back('{rd: wbr_v[sel], data: wbd_v[sel], cyc: cyc});
        if (cs_v[sel])
            bus_q.push_back('{addr: addr_v[sel], data: wdat_v[sel],
                              w: we_v[sel], cyc: cyc});
        drive_inputs();
        bus_respond();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++)
            step();
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        in_valid      = 1'b1;
        in_mem_wr     = 1'b1;
        in_wb_sel     = 1'b1;
        in_rf_wr      = 1'b1;
        in_rd         = 5'd17;
        in_alu_out    = 32'h1111_2222;
        in_store_data = 32'h3333_4444;
        Data_BUS_READ = 32'hFFFF_FFFF;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            cyc++;
            for (int i = 0; i < N; i++) begin
                total++;
                if ({stall_v[i], cs_v[i], we_v[i], wbw_v[i], addr_v[i],
                     wdat_v[i], wbd_v[i], wbr_v[i]} !== '0)
                    $display("FAIL reset_hold dut%0d cyc%0d: got %h want 0", i, c,
                             {stall_v[i], cs_v[i], we_v[i], wbw_v[i], addr_v[i],
                              wdat_v[i], wbd_v[i], wbr_v[i]});
                else
                    passed++;
            end
        end
        rst = 1'b0;
        up_q.delete();
        drive_inputs();
        for (int i = 0; i < N; i++) begin
            total++;
            if ({stall_v[i], cs_v[i], we_v[i], wbw_v[i], addr_v[i],
                 wdat_v[i], wbd_v[i], wbr_v[i]} !== '0)
                $display("FAIL reset_release dut%0d: got %h want 0", i,
                         {stall_v[i], cs_v[i], we_v[i], wbw_v[i], addr_v[i],
                          wdat_v[i], wbd_v[i], wbr_v[i]});
            else
                passed++;
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            total++;
            if ({stall_v[i], cs_v[i], we_v[i], wbw_v[i], addr_v[i],
                 wdat_v[i], wbd_v[i], wbr_v[i]} !== '0)
                $display("FAIL reset_after dut%0d: got %h want 0", i,
                         {stall_v[i], cs_v[i], we_v[i], wbw_v[i], addr_v[i],
                          wdat_v[i], wbd_v[i], wbr_v[i]});
            else
                passed++;
        end
    endtask

    task automatic check_wb(input string name);
        wb_t e;
        wb_t g;
        e = exp_q.pop_front();
        total++;
        if (got_q.size() !== 1) begin
            $display("FAIL %s wb_count: got %0d want 1", name, got_q.size());
            return;
        end
        passed++;
        g = got_q.pop_front();
        total++;
        if (g.rd !== e.rd)
            $display("FAIL %s wb_rd: got %0d want %0d", name, g.rd, e.rd);
        else
            passed++;
        total++;
        if (g.data !== e.data)
            $display("FAIL %s wb_data: got %h want %h", name, g.data, e.data);
        else
            passed++;
        total++;
        if (g.cyc !== e.cyc)
            $display("FAIL %s wb_cycle: got %0d want %0d", name, g.cyc, e.cyc);
        else
            passed++;
    endtask

    task automatic test_alu();
        int k;
        sel = 1;
        clear_mon();
        k = cyc;
        up_q.push_back('{mem_wr: 0, wb_sel: 0, rf_wr: 1, rd: 5'd9,
                         alu: 32'h0000_00A5, sd: 32'h0});
        exp_q.push_back('{rd: 5'd9, data: 32'h0000_00A5, cyc: k + 2});
        drive_inputs();
        run(4);
        total++;
        if (cs_cnt !== 0)
            $display("FAIL alu_cs: got %0d cycles want 0", cs_cnt);
        else
            passed++;
        total++;
        if (stall_cnt !== 0)
            $display("FAIL alu_stall: got %0d cycles want 0", stall_cnt);
        else
            passed++;
        check_wb("alu");
    endtask

    task automatic test_load();
        int k;
        sel = 2;
        clear_mon();
        rdata_cur = 32'hDEAD_BEEF;
        k = cyc;
        up_q.push_back('{mem_wr: 0, wb_sel: 1, rf_wr: 1, rd: 5'd5,
                         alu: 32'h0000_0100, sd: 32'h0});
        exp_q.push_back('{rd: 5'd5, data: 32'hDEAD_BEEF, cyc: k + 4});
        drive_inputs();
        run(7);
        total++;
        if (cs_cnt !== 3)
            $display("FAIL load_cs: got %0d cycles want 3", cs_cnt);
        else
            passed++;
        total++;
        if (we_cnt !== 0)
            $display("FAIL load_we: got %0d cycles want 0", we_cnt);
        else
            passed++;
        total++;
        if (stall_cnt !== 2)
            $display("FAIL load_stall: got %0d cycles want 2", stall_cnt);
        else
            passed++;
        for (int i = 0; i < bus_q.size(); i++) begin
            total++;
            if (bus_q[i].addr !== 32'h0000_0100)
                $display("FAIL load_addr%0d: got %h want %h", i,
                         bus_q[i].addr, 32'h0000_0100);
            else
                passed++;
        end
        check_wb("load");
    endtask

    task automatic test_store();
        sel = 1;
        clear_mon();
        up_q.push_back('{mem_wr: 1, wb_sel: 0, rf_wr: 0, rd: 5'd3,
                         alu: 32'h0000_0040, sd: 32'h0000_1234});
        drive_inputs();
        run(5);
        total++;
        if (cs_cnt !== 2 || we_cnt !== 2)
            $display("FAIL store_cs_we: got cs=%0d we=%0d want 2 2", cs_cnt, we_cnt);
        else
            passed++;
        total++;
        if (stall_cnt !== 1)
            $display("FAIL store_stall: got %0d cycles want 1", stall_cnt);
        else
            passed++;
        for (int i = 0; i < bus_q.size(); i++) begin
            total++;
            if (bus_q[i].addr !== 32'h0000_0040 || bus_q[i].data !== 32'h0000_1234)
                $display("FAIL store_bus%0d: got %h/%h want %h/%h", i,
                         bus_q[i].addr, bus_q[i].data, 32'h0000_0040, 32'h0000_1234);
            else
                passed++;
        end
        total++;
        if (got_q.size() !== 0)
            $display("FAIL store_wb_write: got %0d pulses want 0", got_q.size());
        else
            passed++;
    endtask

    task automatic test_back_to_back();
        int k;
        sel = 1;
        clear_mon();
        rdata_cur = 32'hCAFE_0001;
        k = cyc;
        up_q.push_back('{mem_wr: 0, wb_sel: 1, rf_wr: 1, rd: 5'd7,
                         alu: 32'h0000_0080, sd: 32'h0});
        up_q.push_back('{mem_wr: 1, wb_sel: 0, rf_wr: 0, rd: 5'd0,
                         alu: 32'h0000_0044, sd: 32'h0000_5555});
        exp_q.push_back('{rd: 5'd7, data: 32'hCAFE_0001, cyc: k + 3});
        drive_inputs();
        run(8);
        total++;
        if (cs_cnt !== 4 || we_cnt !== 2)
            $display("FAIL b2b_cs_we: got cs=%0d we=%0d want 4 2", cs_cnt, we_cnt);
        else
            passed++;
        total++;
        if (bus_q.size() !== 4)
            $display("FAIL b2b_bus_len: got %0d want 4", bus_q.size());
        else begin
            passed++;
            total++;
            if (bus_q[2].addr !== 32'h0000_0044 || bus_q[2].cyc !== bus_q[1].cyc + 1)
                $display("FAIL b2b_no_gap: got addr %h cyc %0d want %h cyc %0d",
                         bus_q[2].addr, bus_q[2].cyc, 32'h0000_0044, bus_q[1].cyc + 1);
            else
                passed++;
            total++;
            if (bus_q[1].addr !== 32'h0000_0080 || bus_q[3].data !== 32'h0000_5555)
                $display("FAIL b2b_bus_vals: got %h/%h want %h/%h",
                         bus_q[1].addr, bus_q[3].data, 32'h0000_0080, 32'h0000_5555);
            else
                passed++;
        end
        check_wb("b2b");
    endtask

    task automatic test_reset_mid();
        int k;
        sel = 3;
        clear_mon();
        rdata_cur = 32'h0BAD_F00D;
        up_q.push_back('{mem_wr: 0, wb_sel: 1, rf_wr: 1, rd: 5'd4,
                         alu: 32'h0000_0200, sd: 32'h0});
        drive_inputs();
        run(2);
        rst = 1'b1;
        up_q.delete();
        drive_inputs();
        step();
        total++;
        if (cs_v[3] !== 1'b0 || stall_v[3] !== 1'b0)
            $display("FAIL rstmid_abort: got cs=%b stall=%b want 0 0",
                     cs_v[3], stall_v[3]);
        else
            passed++;
        rst = 1'b0;
        run(6);
        total++;
        if (cs_cnt !== 2)
            $display("FAIL rstmid_cs: got %0d cycles want 2", cs_cnt);
        else
            passed++;
        total++;
        if (got_q.size() !== 0)
            $display("FAIL rstmid_wb_write: got %0d pulses want 0", got_q.size());
        else
            passed++;
        clear_mon();
        k = cyc;
        up_q.push_back('{mem_wr: 0, wb_sel: 0, rf_wr: 1, rd: 5'd11,
                         alu: 32'h0000_0077, sd: 32'h0});
        exp_q.push_back('{rd: 5'd11, data: 32'h0000_0077, cyc: k + 2});
        drive_inputs();
        run(4);
        check_wb("rstmid_alu");
    endtask

    task automatic test_zero_wait();
        int k;
        sel = 0;
        clear_mon();
        rdata_cur = 32'h1357_2468;
        k = cyc;
        up_q.push_back('{mem_wr: 0, wb_sel: 1, rf_wr: 1, rd: 5'd2,
                         alu: 32'h0000_0010, sd: 32'h0});
        exp_q.push_back('{rd: 5'd2, data: 32'h1357_2468, cyc: k + 2});
        drive_inputs();
        run(4);
        total++;
        if (stall_cnt !== 0 || cs_cnt !== 1)
            $display("FAIL zw_stall_cs: got stall=%0d cs=%0d want 0 1",
                     stall_cnt, cs_cnt);
        else
            passed++;
        check_wb("zero_wait");
    endtask

    initial begin
        cyc       = 0;
        sel       = 0;
        passed    = 0;
        total     = 0;
        rdata_cur = '0;
        clear_mon();
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_back_to_back();
        test_reset_mid();
        test_zero_wait();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
